// File: rtl/frame_tx_scheduler.sv
// rtl/frame_tx_scheduler.sv - frame request scheduler for the 10-bit comma/PRBS frame generator
// Optional sync checker on generator output: FRAME_TX_SCHEDULER_CHECK_EN
module frame_tx_scheduler #(
    parameter int PRBS_LENGTH = 8,
    parameter int FRAME_CNT_W = 16,
    parameter int GAP_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic [GAP_W-1:0]       gap_cycles,
    output logic                   send_enable,
    output logic                   busy,
    output logic                   frame_active,
    output logic                   sof,
    output logic                   eof,
    output logic [FRAME_CNT_W-1:0] frames_sent,
    output logic                   done
`ifdef FRAME_TX_SCHEDULER_CHECK_EN
    ,
    input  logic [9:0]             gen_data,
    output logic                   sync_err
`endif
);

    localparam int PW = $clog2(PRBS_LENGTH + 2);
    localparam logic [PW-1:0] POS_PRE  = PW'(PRBS_LENGTH);
    localparam logic [PW-1:0] POS_LAST = PW'(PRBS_LENGTH + 1);
    localparam logic [FRAME_CNT_W:0] CNT_ONE_X = (FRAME_CNT_W+1)'(1);

    typedef enum logic [2:0] {IDLE, REQ, FRAME, GAP, DONE} state_t;

    state_t                 state;
    logic [PW-1:0]          pos;
    logic [GAP_W-1:0]       gcnt;
    logic [FRAME_CNT_W-1:0] cfg_num;
    logic [GAP_W-1:0]       cfg_gap;
    logic                   abort_pending;
    logic                   req_q;
    logic                   stop;
    logic                   more;

    assign stop = abort | abort_pending;
    // frames_sent has not yet counted the frame whose tail is being decided
    assign more = (cfg_num == '0) ||
                  (({1'b0, frames_sent} + CNT_ONE_X) < {1'b0, cfg_num});

    // Abort must be able to cancel a request in the very cycle it is presented
    assign send_enable = req_q & ~stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pos           <= '0;
            gcnt          <= '0;
            cfg_num       <= '0;
            cfg_gap       <= '0;
            abort_pending <= 1'b0;
            req_q         <= 1'b0;
            busy          <= 1'b0;
            frame_active  <= 1'b0;
            sof           <= 1'b0;
            eof           <= 1'b0;
            frames_sent   <= '0;
            done          <= 1'b0;
        end else begin
            req_q        <= 1'b0;
            sof          <= 1'b0;
            eof          <= 1'b0;
            frame_active <= 1'b0;
            done         <= 1'b0;
            if (state != IDLE && abort)
                abort_pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= REQ;
                        cfg_num       <= num_frames;
                        cfg_gap       <= gap_cycles;
                        frames_sent   <= '0;
                        abort_pending <= 1'b0;
                        busy          <= 1'b1;
                        req_q         <= 1'b1;
                    end
                end
                REQ: begin
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= FRAME;
                        pos          <= '0;
                        sof          <= 1'b1;
                        frame_active <= 1'b1;
                    end
                end
                FRAME: begin
                    if (pos == POS_LAST) begin
                        if (frames_sent != '1)
                            frames_sent <= frames_sent + FRAME_CNT_W'(1);
                        if (more && !stop && cfg_gap == '0) begin
                            pos          <= '0;
                            sof          <= 1'b1;
                            frame_active <= 1'b1;
                        end else if (more && !stop) begin
                            state <= GAP;
                            gcnt  <= cfg_gap;
                            req_q <= (cfg_gap == GAP_W'(1));
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        pos          <= pos + PW'(1);
                        frame_active <= 1'b1;
                        if (pos == POS_PRE) begin
                            eof   <= 1'b1;
                            req_q <= more && (cfg_gap == '0);
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (gcnt == GAP_W'(1)) begin
                        state        <= FRAME;
                        pos          <= '0;
                        sof          <= 1'b1;
                        frame_active <= 1'b1;
                    end else begin
                        gcnt  <= gcnt - GAP_W'(1);
                        req_q <= (gcnt == GAP_W'(2));
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_TX_SCHEDULER_CHECK_EN
    localparam logic [9:0] COMMA = 10'b1100110011;

    always_ff @(posedge clk) begin
        if (rst)
            sync_err <= 1'b0;
        else if (state == IDLE && start)
            sync_err <= 1'b0;
        else if (((sof || eof) && gen_data != COMMA) ||
                 (state == GAP && gen_data != 10'd0))
            sync_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb/tb_frame_tx_scheduler.sv - directed self-checking bench for frame_tx_scheduler
module tb_frame_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_frames;
    logic [7:0]  gap_cycles;
    logic        send_enable;
    logic        busy;
    logic        frame_active;
    logic        sof;
    logic        eof;
    logic [15:0] frames_sent;
    logic        done;
`ifdef FRAME_TX_SCHEDULER_CHECK_EN
    logic [9:0]  gen_data = 10'd0;
    logic        sync_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sof_v, eof_v, se_v, done_v, busy_v;
    logic [15:0] fs_at_done, fs_end;

    frame_tx_scheduler #(.PRBS_LENGTH(8), .FRAME_CNT_W(16), .GAP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_frames   (num_frames),
        .gap_cycles   (gap_cycles),
        .send_enable  (send_enable),
        .busy         (busy),
        .frame_active (frame_active),
        .sof          (sof),
        .eof          (eof),
        .frames_sent  (frames_sent),
        .done         (done)
`ifdef FRAME_TX_SCHEDULER_CHECK_EN
        ,
        .gen_data     (gen_data),
        .sync_err     (sync_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bits(input int a, input int b = -1, input int c = -1);
        logic [63:0] m = '0;
        m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    // Index 0 of every trace is the cycle in which start is high
    task automatic run(input int ncyc, input int abort_at, input logic [15:0] nf, input logic [7:0] gp);
        num_frames = nf;
        gap_cycles = gp;
        sof_v = '0; eof_v = '0; se_v = '0; done_v = '0; busy_v = '0;
        fs_at_done = 16'hdead;
        for (int i = 0; i < ncyc; i++) begin
            start = (i == 0);
            abort = (i == abort_at);
            @(negedge clk);
            sof_v[i]  = sof;
            eof_v[i]  = eof;
            se_v[i]   = send_enable;
            done_v[i] = done;
            busy_v[i] = busy;
            if (done) fs_at_done = frames_sent;
            fs_end = frames_sent;
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_frames = '0; gap_cycles = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({send_enable, busy, frame_active, sof, eof, done, frames_sent}), 64'd0);
        @(posedge clk); #1;

        // three back-to-back frames
        run(40, -1, 16'd3, 8'd0);
        check("b2b_sof", sof_v, bits(2, 12, 22));
        check("b2b_eof", eof_v, bits(11, 21, 31));
        check("b2b_send_enable", se_v, bits(1, 11, 21));
        check("b2b_done", done_v, bits(32));
        check("b2b_busy", busy_v, span(1, 32));
        check("b2b_frames_sent", 64'(fs_at_done), 64'd3);
        check("b2b_frames_hold", 64'(fs_end), 64'd3);

        // two frames separated by a 4-cycle gap
        run(40, -1, 16'd2, 8'd4);
        check("gap_sof", sof_v, bits(2, 16));
        check("gap_eof", eof_v, bits(11, 25));
        check("gap_send_enable", se_v, bits(1, 15));
        check("gap_done", done_v, bits(26));
        check("gap_busy", busy_v, span(1, 26));
        check("gap_frames_sent", 64'(fs_at_done), 64'd2);

        // continuous mode aborted in the middle of frame 2
        run(40, 15, 16'd0, 8'd0);
        check("abt_frame_sof", sof_v, bits(2, 12));
        check("abt_frame_eof", eof_v, bits(11, 21));
        check("abt_frame_send_enable", se_v, bits(1, 11));
        check("abt_frame_done", done_v, bits(22));
        check("abt_frame_frames_sent", 64'(fs_at_done), 64'd2);

        // abort on the final gap cycle, where the request would be issued
        run(40, 16, 16'd2, 8'd5);
        check("abt_gap_sof", sof_v, bits(2));
        check("abt_gap_send_enable", se_v, bits(1));
        check("abt_gap_done", done_v, bits(17));
        check("abt_gap_frames_sent", 64'(fs_at_done), 64'd1);

        // start and abort together: start wins
        run(20, 0, 16'd1, 8'd0);
        check("start_abort_sof", sof_v, bits(2));
        check("start_abort_send_enable", se_v, bits(1));
        check("start_abort_done", done_v, bits(12));
        check("start_abort_frames_sent", 64'(fs_at_done), 64'd1);

        // abort during the request cycle
        run(10, 1, 16'd3, 8'd0);
        check("abt_req_send_enable", se_v, 64'd0);
        check("abt_req_sof", sof_v, 64'd0);
        check("abt_req_done", done_v, bits(2));
        check("abt_req_frames_sent", 64'(fs_at_done), 64'd0);

        // second start while busy is ignored, then reset mid-frame
        sof_v = '0; eof_v = '0; se_v = '0; busy_v = '0;
        for (int i = 0; i < 16; i++) begin
            start = (i == 0) || (i == 5);
            rst   = (i == 14);
            if (i == 0) begin num_frames = 16'd3; gap_cycles = 8'd0; end
            if (i == 5) begin num_frames = 16'd1; gap_cycles = 8'd7; end
            @(negedge clk);
            sof_v[i]  = sof;
            eof_v[i]  = eof;
            se_v[i]   = send_enable;
            busy_v[i] = busy;
            if (i == 15)
                check("post_rst_outputs",
                      64'({send_enable, busy, frame_active, sof, eof, done, frames_sent}), 64'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        check("busy_start_send_enable", se_v, bits(1, 11));
        check("busy_start_sof", sof_v, bits(2, 12));
        check("busy_start_eof", eof_v, bits(11));
        check("busy_start_busy", busy_v, span(1, 14));

        run(40, -1, 16'd3, 8'd0);
        check("rerun_sof", sof_v, bits(2, 12, 22));
        check("rerun_eof", eof_v, bits(11, 21, 31));
        check("rerun_send_enable", se_v, bits(1, 11, 21));
        check("rerun_done", done_v, bits(32));
        check("rerun_frames_sent", 64'(fs_at_done), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
